// File: rtl/wdt_kick_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// wdt_ctrl_pkg
// Shared definitions for the watchdog kick controller:
//   - key_state_e : key-sequence FSM state encoding
//   - ADDR_*      : word addresses of the register map
//   - CTRL_* / STAT_* : bit positions inside CTRL and STATUS
//   - sat_inc8()  : saturating 8-bit increment used by the reset counter
//   - timeout_fix(): maps a TIMEOUT write of 0 to 1
// Optional feature macro used by the design: WDT_CTRL_LOCK_EN
// -----------------------------------------------------------------------------
package wdt_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_IDLE     = 2'd1,
        ST_ARMED    = 2'd2,
        ST_KICK     = 2'd3
    } key_state_e;

    localparam logic [1:0] ADDR_CTRL    = 2'd0;
    localparam logic [1:0] ADDR_TIMEOUT = 2'd1;
    localparam logic [1:0] ADDR_KICK    = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    localparam int CTRL_EN_BIT      = 0;
    localparam int CTRL_LOCK_BIT    = 1;

    localparam int STAT_EN_BIT      = 0;
    localparam int STAT_LOCK_BIT    = 1;
    localparam int STAT_ARMED_BIT   = 2;
    localparam int STAT_KEY_ERR_BIT = 3;
    localparam int STAT_RST_CNT_LSB = 8;

    // Reset counter stops at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        logic [7:0] result;
        if (value == 8'hFF) begin
            result = 8'hFF;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

    // A zero timeout would make the watchdog fire immediately; store 1 instead.
    function automatic logic [31:0] timeout_fix(input logic [31:0] value);
        logic [31:0] result;
        if (value == 32'h0000_0000) begin
            result = 32'h0000_0001;
        end else begin
            result = value;
        end
        return result;
    endfunction

endpackage

// File: rtl/wdt_kick_ctrl_if.sv
// -----------------------------------------------------------------------------
// wdt_kick_ctrl_if
// Peripheral bus between a bus master and the watchdog kick controller.
//   req_i   : request             (master -> slave)
//   we_i    : write enable        (master -> slave)
//   addr_i  : 2-bit word address  (master -> slave)
//   wdata_i : 32-bit write data   (master -> slave)
//   gnt_o   : grant, equals req_i (slave -> master)
//   rvalid_o: response valid one cycle after a granted request
//   rdata_o : read data, valid with rvalid_o, 0 for writes
// Signal names keep the controller-side direction suffixes so they line up
// with the controller's port list.
// -----------------------------------------------------------------------------
interface wdt_kick_ctrl_if;
    logic        req_i;
    logic        we_i;
    logic [1:0]  addr_i;
    logic [31:0] wdata_i;
    logic        gnt_o;
    logic        rvalid_o;
    logic [31:0] rdata_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o
    );
endinterface

// File: rtl/wdt_kick_ctrl_key_seq.sv
// -----------------------------------------------------------------------------
// wdt_key_seq
// Key-sequence FSM and key window counter. A kick pulse is produced only
// after KEY1 followed by KEY2 within KEY_WINDOW cycles.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   en_set        : accepted CTRL write with en = 1
//   en_clr        : accepted CTRL write with en = 0 (highest priority)
//   kick_wr       : accepted write to the KICK register
//   kick_data     : data of that write
//   wdt_rise      : rising edge of the watchdog system reset
//   kick          : registered kick to the watchdog (1 in DISABLED and KICK)
//   armed         : registered, 1 while waiting for KEY2
//   key_err_set   : one-cycle request to set the sticky key error flag
// -----------------------------------------------------------------------------
module wdt_key_seq
    import wdt_ctrl_pkg::*;
#(
    parameter int          KEY_WINDOW = 16,
    parameter logic [31:0] KEY1       = 32'h0000_A5A5,
    parameter logic [31:0] KEY2       = 32'h0000_5A5A
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_set,
    input  logic        en_clr,
    input  logic        kick_wr,
    input  logic [31:0] kick_data,
    input  logic        wdt_rise,
    output logic        kick,
    output logic        armed,
    output logic        key_err_set
);

    localparam int               CNT_W    = $clog2(KEY_WINDOW + 1);
    localparam logic [CNT_W-1:0] WIN_LOAD = CNT_W'(KEY_WINDOW);
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(1);
    localparam logic [CNT_W-1:0] WIN_ZERO = {CNT_W{1'b0}};

    key_state_e       state_r;
    key_state_e       state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             kick_s;
    logic             armed_s;
    logic             kick_r;
    logic             armed_r;
    logic             key_err_set_s;

    // State and window counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_DISABLED;
            cnt_r   <= WIN_ZERO;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next-state logic. Disable beats everything, then the watchdog reset,
    // then the key writes. The counter is loaded with KEY_WINDOW on KEY1;
    // the cycle holding 1 is the last one in which KEY2 is still taken,
    // after which the counter would hit 0 and the sequence silently expires.
    always_comb begin
        state_s       = state_r;
        cnt_s         = cnt_r;
        key_err_set_s = 1'b0;
        if (en_clr) begin
            state_s = ST_DISABLED;
            cnt_s   = WIN_ZERO;
        end else if (state_r == ST_DISABLED) begin
            cnt_s = WIN_ZERO;
            if (en_set) begin
                state_s = ST_IDLE;
            end else begin
                state_s = ST_DISABLED;
            end
        end else if (wdt_rise) begin
            state_s = ST_IDLE;
            cnt_s   = WIN_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (kick_wr) begin
                        if (kick_data == KEY1) begin
                            state_s = ST_ARMED;
                            cnt_s   = WIN_LOAD;
                        end else begin
                            state_s       = ST_IDLE;
                            key_err_set_s = 1'b1;
                        end
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_ARMED: begin
                    if (kick_wr) begin
                        cnt_s = WIN_ZERO;
                        if (kick_data == KEY2) begin
                            state_s = ST_KICK;
                        end else begin
                            state_s       = ST_IDLE;
                            key_err_set_s = 1'b1;
                        end
                    end else if (cnt_r <= WIN_LAST) begin
                        state_s = ST_IDLE;
                        cnt_s   = WIN_ZERO;
                    end else begin
                        state_s = ST_ARMED;
                        cnt_s   = cnt_r - WIN_LAST;
                    end
                end
                ST_KICK: begin
                    state_s = ST_IDLE;
                    cnt_s   = WIN_ZERO;
                end
                default: begin
                    state_s = ST_DISABLED;
                    cnt_s   = WIN_ZERO;
                end
            endcase
        end
    end

    // Output decode, taken from the next state so the outputs can be
    // registered without adding latency.
    always_comb begin
        kick_s  = 1'b0;
        armed_s = 1'b0;
        case (state_s)
            ST_DISABLED: kick_s  = 1'b1;
            ST_KICK:     kick_s  = 1'b1;
            ST_ARMED:    armed_s = 1'b1;
            ST_IDLE:     kick_s  = 1'b0;
            default:     kick_s  = 1'b1;
        endcase
    end

    // Glitch-free output registers; kick resets high to hold the watchdog clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kick_r  <= 1'b1;
            armed_r <= 1'b0;
        end else begin
            kick_r  <= kick_s;
            armed_r <= armed_s;
        end
    end

    assign kick        = kick_r;
    assign armed       = armed_r;
    assign key_err_set = key_err_set_s;

endmodule

// File: rtl/wdt_kick_ctrl.sv
// -----------------------------------------------------------------------------
// wdt_kick_ctrl
// Register-mapped sequencer for one watchdog instance: holds the timeout,
// gates enable, produces kicks only after a two-word key sequence and counts
// watchdog-triggered resets.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   bus          : peripheral bus (wdt_kick_ctrl_if.slave)
//   kick_o       : to watchdog kick_i (held 1 while disabled)
//   timeout_o    : to watchdog timeout_i (TIMEOUT register)
//   wdt_rst_i    : from watchdog sys_rst_o
//   key_err_o    : sticky key-error flag (STATUS.key_err)
// Register map: 0 CTRL {lock,en}, 1 TIMEOUT, 2 KICK (write-only),
//   3 STATUS {rst_cnt[15:8], key_err[3], armed[2], lock[1], en[0]};
//   writing 1 to STATUS bit3 clears key_err.
// Optional feature: define WDT_CTRL_LOCK_EN to make CTRL.lock a sticky bit
// that freezes CTRL and TIMEOUT until reset; otherwise lock reads 0.
// -----------------------------------------------------------------------------
module wdt_kick_ctrl
    import wdt_ctrl_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_RST = 32'd1000,
    parameter int          KEY_WINDOW  = 16,
    parameter logic [31:0] KEY1        = 32'h0000_A5A5,
    parameter logic [31:0] KEY2        = 32'h0000_5A5A
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    wdt_kick_ctrl_if.slave       bus,
    output logic                 kick_o,
    output logic [31:0]          timeout_o,
    input  logic                 wdt_rst_i,
    output logic                 key_err_o
);

    logic        wr_s;
    logic        rd_s;
    logic        ctrl_wr_s;
    logic        tmo_wr_s;
    logic        kick_wr_s;
    logic        key_err_clr_s;
    logic        en_set_s;
    logic        en_clr_s;
    logic        wdt_rise_s;
    logic        lock_s;
    logic        armed_s;
    logic        kick_s;
    logic        key_err_set_s;
    logic [31:0] status_s;
    logic [31:0] rdata_s;

    logic        en_r;
    logic [31:0] timeout_r;
    logic        key_err_r;
    logic [7:0]  rst_cnt_r;
    logic        wdt_rst_q_r;
    logic        rvalid_r;
    logic [31:0] rdata_r;

    // Bus decode; lock_s gates CTRL and TIMEOUT writes only.
    assign wr_s          = bus.req_i & bus.we_i;
    assign rd_s          = bus.req_i & ~bus.we_i;
    assign ctrl_wr_s     = wr_s & (bus.addr_i == ADDR_CTRL) & ~lock_s;
    assign tmo_wr_s      = wr_s & (bus.addr_i == ADDR_TIMEOUT) & ~lock_s;
    assign kick_wr_s     = wr_s & (bus.addr_i == ADDR_KICK);
    assign key_err_clr_s = wr_s & (bus.addr_i == ADDR_STATUS) & bus.wdata_i[STAT_KEY_ERR_BIT];
    assign en_set_s      = ctrl_wr_s & bus.wdata_i[CTRL_EN_BIT];
    assign en_clr_s      = ctrl_wr_s & ~bus.wdata_i[CTRL_EN_BIT];
    assign wdt_rise_s    = wdt_rst_i & ~wdt_rst_q_r;

`ifdef WDT_CTRL_LOCK_EN
    logic lock_r;

    // Sticky lock: once set only rst_i clears it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock_r <= 1'b0;
        end else if (ctrl_wr_s && bus.wdata_i[CTRL_LOCK_BIT]) begin
            lock_r <= 1'b1;
        end else begin
            lock_r <= lock_r;
        end
    end

    assign lock_s = lock_r;
`else
    assign lock_s = 1'b0;
`endif

    wdt_key_seq #(
        .KEY_WINDOW (KEY_WINDOW),
        .KEY1       (KEY1),
        .KEY2       (KEY2)
    ) u_key_seq (
        .clk         (clk_i),
        .rst         (rst_i),
        .en_set      (en_set_s),
        .en_clr      (en_clr_s),
        .kick_wr     (kick_wr_s),
        .kick_data   (bus.wdata_i),
        .wdt_rise    (wdt_rise_s),
        .kick        (kick_s),
        .armed       (armed_s),
        .key_err_set (key_err_set_s)
    );

    assign status_s = {16'h0000, rst_cnt_r, 4'h0, key_err_r, armed_s, lock_s, en_r};

    // Read data mux; writes return 0.
    always_comb begin
        rdata_s = 32'h0000_0000;
        if (rd_s) begin
            case (bus.addr_i)
                ADDR_CTRL:    rdata_s = {30'd0, lock_s, en_r};
                ADDR_TIMEOUT: rdata_s = timeout_r;
                ADDR_KICK:    rdata_s = 32'h0000_0000;
                ADDR_STATUS:  rdata_s = status_s;
                default:      rdata_s = 32'h0000_0000;
            endcase
        end else begin
            rdata_s = 32'h0000_0000;
        end
    end

    // Registered bus response, one cycle after each request.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rvalid_r <= 1'b0;
            rdata_r  <= 32'h0000_0000;
        end else begin
            rvalid_r <= bus.req_i;
            rdata_r  <= rdata_s;
        end
    end

    // CTRL.en and TIMEOUT configuration registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            en_r      <= 1'b0;
            timeout_r <= TIMEOUT_RST;
        end else begin
            if (ctrl_wr_s) begin
                en_r <= bus.wdata_i[CTRL_EN_BIT];
            end
            if (tmo_wr_s) begin
                timeout_r <= timeout_fix(bus.wdata_i);
            end
        end
    end

    // Sticky key error; set and clear come from different addresses so they
    // never coincide, but clear is given priority anyway.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            key_err_r <= 1'b0;
        end else if (key_err_clr_s) begin
            key_err_r <= 1'b0;
        end else if (key_err_set_s) begin
            key_err_r <= 1'b1;
        end else begin
            key_err_r <= key_err_r;
        end
    end

    // Watchdog reset edge detector and saturating reset counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wdt_rst_q_r <= 1'b0;
            rst_cnt_r   <= 8'h00;
        end else begin
            wdt_rst_q_r <= wdt_rst_i;
            if (wdt_rise_s) begin
                rst_cnt_r <= sat_inc8(rst_cnt_r);
            end
        end
    end

    assign bus.gnt_o    = bus.req_i;
    assign bus.rvalid_o = rvalid_r;
    assign bus.rdata_o  = rdata_r;
    assign kick_o       = kick_s;
    assign timeout_o    = timeout_r;
    assign key_err_o    = key_err_r;

endmodule

// File: tb/tb_wdt_kick_ctrl.sv
module tb_wdt_kick_ctrl;

    localparam int          KW   = 16;
    localparam logic [31:0] K1   = 32'h0000_A5A5;
    localparam logic [31:0] K2   = 32'h0000_5A5A;
    localparam logic [31:0] TRST = 32'd1000;
`ifdef WDT_CTRL_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        wdt_rst;
    logic        kick;
    logic [31:0] tmo;
    logic        key_err;

    wdt_kick_ctrl_if bus();

    wdt_kick_ctrl #(
        .TIMEOUT_RST (TRST),
        .KEY_WINDOW  (KW),
        .KEY1        (K1),
        .KEY2        (K2)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .bus       (bus),
        .kick_o    (kick),
        .timeout_o (tmo),
        .wdt_rst_i (wdt_rst),
        .key_err_o (key_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: registers plus a "KEY1 accepted at cycle t" timestamp.
    bit          m_en, m_lock, m_key_err, m_armed, m_kickst, m_prev_wdt;
    logic [31:0] m_timeout;
    int          m_rst_cnt, m_key1_t, cyc;
    // Behavioural watchdog used as stimulus source when use_wd is set.
    bit          use_wd, wdt_drv;
    int          wd_cnt, wd_hold, wd_fires;
    logic [31:0] last_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [1:0] a);
        logic [31:0] v;
        case (a)
            2'd0:    v = {30'd0, m_lock, m_en};
            2'd1:    v = m_timeout;
            2'd3:    v = {16'd0, 8'(m_rst_cnt), 4'd0, m_key_err, m_armed, m_lock, m_en};
            default: v = 32'd0;
        endcase
        return v;
    endfunction

    task automatic m_reset();
        m_en = 1'b0; m_lock = 1'b0; m_key_err = 1'b0; m_armed = 1'b0;
        m_kickst = 1'b0; m_prev_wdt = 1'b0; m_timeout = TRST;
        m_rst_cnt = 0; m_key1_t = 0; cyc = 0;
        wd_cnt = 0; wd_hold = 0;
    endtask

    // One bus cycle: drive, predict, clock, compare.
    task automatic step(input bit req, input bit we, input logic [1:0] addr, input logic [31:0] wd);
        bit          wv, rise, wr, ctrl_ok, kwr, cur_kick, e_rvalid;
        logic [31:0] e_rdata, tpre;
        wv = use_wd ? (wd_hold > 0) : wdt_drv;
        bus.req_i = req; bus.we_i = we; bus.addr_i = addr; bus.wdata_i = wd;
        wdt_rst = wv;
        #1;
        chk1("gnt", bus.gnt_o, req);
        if (m_armed && (cyc - m_key1_t) > KW) m_armed = 1'b0;
        e_rvalid = req;
        e_rdata  = (req && !we) ? m_read(addr) : 32'd0;
        cur_kick = !m_en || m_kickst;
        tpre     = m_timeout;
        wr       = req && we;
        ctrl_ok  = wr && (addr == 2'd0) && !m_lock;
        kwr      = wr && (addr == 2'd2);
        rise     = wv && !m_prev_wdt;
        if (ctrl_ok && !wd[0]) begin
            m_armed = 1'b0; m_kickst = 1'b0;
        end else if (!m_en) begin
            m_armed = 1'b0; m_kickst = 1'b0;
        end else if (rise) begin
            m_armed = 1'b0; m_kickst = 1'b0;
        end else if (m_kickst) begin
            m_kickst = 1'b0;
        end else if (kwr) begin
            if (m_armed) begin
                m_armed = 1'b0;
                if (wd == K2) m_kickst = 1'b1;
                else          m_key_err = 1'b1;
            end else if (wd == K1) begin
                m_armed = 1'b1; m_key1_t = cyc;
            end else begin
                m_key_err = 1'b1;
            end
        end
        if (ctrl_ok) begin
            m_en = wd[0];
            if (LOCK_EN && wd[1]) m_lock = 1'b1;
        end
        if (wr && addr == 2'd1 && !m_lock) m_timeout = (wd == 32'd0) ? 32'd1 : wd;
        if (wr && addr == 2'd3 && wd[3]) m_key_err = 1'b0;
        if (rise && m_rst_cnt < 255) m_rst_cnt++;
        m_prev_wdt = wv;
        if (use_wd) begin
            if (wd_hold > 0) wd_hold--;
            else if (cur_kick) wd_cnt = 0;
            else begin
                wd_cnt++;
                if (wd_cnt >= int'(tpre)) begin
                    wd_hold = 3; wd_cnt = 0; wd_fires++;
                end
            end
        end
        cyc++;
        @(posedge clk); #1;
        last_rdata = bus.rdata_o;
        chk1("rvalid", bus.rvalid_o, e_rvalid);
        chk("rdata", bus.rdata_o, e_rdata);
        chk1("kick", kick, !m_en || m_kickst);
        chk("timeout", tmo, m_timeout);
        chk1("key_err", key_err, m_key_err);
    endtask

    task automatic idle(); step(1'b0, 1'b0, 2'd0, 32'd0); endtask
    task automatic wr(input logic [1:0] a, input logic [31:0] d); step(1'b1, 1'b1, a, d); endtask
    task automatic rd(input logic [1:0] a); step(1'b1, 1'b0, a, 32'd0); endtask

    task automatic reset_dut();
        rst = 1'b1;
        bus.req_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = 2'd0; bus.wdata_i = 32'd0;
        wdt_rst = 1'b0; wdt_drv = 1'b0; use_wd = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        m_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        wd_fires = 0;
        reset_dut();
        chk1("rst_kick", kick, 1'b1);
        chk("rst_timeout", tmo, 32'd1000);
        chk1("rst_rvalid", bus.rvalid_o, 1'b0);
        chk("rst_rdata", bus.rdata_o, 32'd0);
        rd(2'd3);
        chk("status_after_reset", last_rdata, 32'h0000_0000);
        wr(2'd0, 32'd1);
        chk1("kick_after_en", kick, 1'b0);

        // KEY1, KEY2 three cycles later -> single pulse.
        wr(2'd2, K1);
        rd(2'd3);
        chk1("armed_between_keys", last_rdata[2], 1'b1);
        idle();
        wr(2'd2, K2);
        chk1("kick_pulse", kick, 1'b1);
        idle();
        chk1("kick_pulse_end", kick, 1'b0);

        // Last accepted KEY2 position: KW cycles after KEY1.
        wr(2'd2, K1);
        repeat (KW - 1) idle();
        wr(2'd2, K2);
        chk1("kick_window_edge", kick, 1'b1);
        idle();

        // One cycle too late: expiry is silent, the stray KEY2 sets key_err.
        wr(2'd2, K1);
        repeat (KW) idle();
        chk1("no_err_on_expire", key_err, 1'b0);
        wr(2'd2, K2);
        chk1("key_err_stray", key_err, 1'b1);
        chk1("no_kick_late", kick, 1'b0);
        wr(2'd3, 32'h8);
        chk1("key_err_cleared", key_err, 1'b0);

        // Watchdog fires with TIMEOUT = 20 and no kicks.
        reset_dut();
        use_wd = 1'b1;
        wd_fires = 0;
        wr(2'd1, 32'd20);
        wr(2'd0, 32'd1);
        for (int i = 0; i < 100 && wd_fires == 0; i++) idle();
        chk("wd_fired", 32'(wd_fires), 32'd1);
        repeat (4) idle();
        rd(2'd3);
        chk("status_after_wd", last_rdata, 32'h0000_0101);
        use_wd = 1'b0;
        wr(2'd1, 32'd0);
        rd(2'd1);
        chk("timeout_zero_is_one", last_rdata, 32'd1);
        // Level held high counts once.
        wdt_drv = 1'b1;
        repeat (5) idle();
        wdt_drv = 1'b0;
        rd(2'd3);
        chk("rst_cnt_level_once", 32'(last_rdata[15:8]), 32'd2);

        // Lock behaviour.
        reset_dut();
        wr(2'd0, 32'd3);
        wr(2'd1, 32'd50);
        wr(2'd0, 32'd0);
        rd(2'd1);
        chk("lock_timeout", last_rdata, LOCK_EN ? 32'd1000 : 32'd50);
        rd(2'd0);
        chk1("lock_en", last_rdata[0], LOCK_EN);

        // Disable while armed, then KEY2: stays disabled, no extra pulse.
        reset_dut();
        wr(2'd0, 32'd1);
        wr(2'd2, K1);
        wr(2'd0, 32'd0);
        chk1("dis_kick_held", kick, 1'b1);
        wr(2'd2, K2);
        chk1("dis_kick_still", kick, 1'b1);
        chk1("dis_no_key_err", key_err, 1'b0);
        rd(2'd3);
        chk("dis_status", last_rdata, 32'd0);

        // Asynchronous reset mid-sequence.
        reset_dut();
        wr(2'd1, 32'd77);
        wr(2'd0, 32'd1);
        wr(2'd2, K1);
        bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = 2'd3;
        #3 rst = 1'b1;
        #1;
        chk1("async_rst_kick", kick, 1'b1);
        chk("async_rst_timeout", tmo, 32'd1000);
        chk1("async_rst_rvalid", bus.rvalid_o, 1'b0);
        chk1("async_rst_key_err", key_err, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        m_reset();
        rd(2'd3);
        chk("status_after_async_rst", last_rdata, 32'd0);

        // Randomized traffic against the model.
        reset_dut();
        wr(2'd0, 32'd1);
        for (int i = 0; i < 1500; i++) begin
            int          r;
            logic [31:0] d;
            r = $urandom_range(0, 15);
            if ($urandom_range(0, 31) == 0) wdt_drv = ~wdt_drv;
            if (r <= 5) begin
                case ($urandom_range(0, 4))
                    0, 1:    d = K1;
                    2, 3:    d = K2;
                    default: d = $urandom;
                endcase
                wr(2'd2, d);
            end else if (r == 6) begin
                d = 32'd0;
                d[0] = ($urandom_range(0, 7) != 0);
                d[1] = ($urandom_range(0, 15) == 0);
                wr(2'd0, d);
            end else if (r == 7) begin
                d = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
                wr(2'd1, d);
            end else if (r == 8) begin
                d = $urandom;
                wr(2'd3, d);
            end else if (r <= 11) begin
                rd(2'($urandom_range(0, 3)));
            end else begin
                repeat ($urandom_range(1, 12)) idle();
            end
        end

        // Reset counter saturation.
        reset_dut();
        for (int i = 0; i < 560; i++) begin
            wdt_drv = ~wdt_drv;
            idle();
        end
        wdt_drv = 1'b0;
        rd(2'd3);
        chk("rst_cnt_saturated", 32'(last_rdata[15:8]), 32'd255);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
